vc_rr_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one val/rdy output stream between p_nreqs input streams.
- It owns the select of an internal N:1 message mux and sequences grants so each message is transferred intact.
- It holds a grant while the output is back-pressured.
- It sits in front of shared resources such as a memory request port that is multiplexed between fetch and data requesters.

---
 rtl/vc_rr_stream_arbiter.sv | 137 +++++++++++++
 tb/tb_vc_rr_stream_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_rr_stream_arbiter
// Purpose  : Round-robin arbiter sharing one val/rdy output stream between
//            p_nreqs input streams. Drives the select of an internal N:1
//            message mux and locks the grant while the output is
//            back-pressured, so every message is transferred intact.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset
//            in_val   - per-requester valid          [p_nreqs]
//            in_rdy   - per-requester ready          [p_nreqs]
//            in_msg   - flattened messages, req i at [i*p_nbits +: p_nbits]
//            out_val  - output valid
//            out_rdy  - output ready
//            out_msg  - message of the granted requester [p_nbits]
//            grant    - one-hot grant, zero when nothing granted [p_nreqs]
//            sel      - granted index, holds last value when idle [p_sbits]
// Revision : 1.0 - initial release
// ============================================================================
module vc_rr_stream_arbiter #(
    parameter  int p_nbits = 32,
    parameter  int p_nreqs = 4,
    localparam int p_sbits = (p_nreqs > 1) ? $clog2(p_nreqs) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [p_nreqs-1:0]         in_val,
    output logic [p_nreqs-1:0]         in_rdy,
    input  logic [p_nreqs*p_nbits-1:0] in_msg,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [p_nbits-1:0]         out_msg,
    output logic [p_nreqs-1:0]         grant,
    output logic [p_sbits-1:0]         sel
);

    localparam logic       c_ST_OPEN   = 1'b0;
    localparam logic       c_ST_LOCKED = 1'b1;
    localparam logic [p_sbits:0] c_N_EXT = (p_sbits+1)'(p_nreqs);

    logic               state_q,    state_d;
    logic [p_sbits-1:0] prio_q,     prio_d;
    logic [p_sbits-1:0] lock_idx_q, lock_idx_d;
    logic [p_sbits-1:0] sel_hold_q, sel_hold_d;

    logic [p_nreqs-1:0] w_val_rot;
    logic               w_found;
    logic [p_sbits-1:0] w_off;
    logic [p_sbits:0]   w_sum;
    logic [p_sbits-1:0] w_scan_idx;
    logic [p_sbits-1:0] w_winner;
    logic               w_have;
    logic [p_nreqs-1:0] w_onehot;
    logic               w_out_val;
    logic [p_nbits-1:0] w_msg;
    logic [p_sbits:0]   w_inc;

    // Arbitration datapath: rotate valids so bit 0 is the priority holder,
    // find the first set bit, then rotate the offset back to an index.
    always_comb begin
        w_val_rot = p_nreqs'({in_val, in_val} >> prio_q);
        w_found   = 1'b0;
        w_off     = '0;
        for (int k = p_nreqs - 1; k >= 0; k--) begin
            if (w_val_rot[k]) begin
                w_found = 1'b1;
                w_off   = p_sbits'(k);
            end
        end
        w_sum      = {1'b0, prio_q} + {1'b0, w_off};
        w_scan_idx = (w_sum >= c_N_EXT) ? p_sbits'(w_sum - c_N_EXT) : p_sbits'(w_sum);
        // Under a lock the held requester wins even if its val has dropped.
        w_winner   = (state_q == c_ST_LOCKED) ? lock_idx_q : w_scan_idx;
        w_have     = (state_q == c_ST_LOCKED) || w_found;
        w_onehot   = '0;
        w_msg      = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (w_have && (w_winner == p_sbits'(i))) begin
                w_onehot[i] = 1'b1;
                w_msg       = in_msg[i*p_nbits +: p_nbits];
            end
        end
        w_out_val = |(in_val & w_onehot);
        w_inc     = {1'b0, w_winner} + (p_sbits+1)'(1);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_ST_OPEN;
            prio_q     <= '0;
            lock_idx_q <= '0;
            sel_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_idx_q <= lock_idx_d;
            sel_hold_q <= sel_hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_idx_d = lock_idx_q;
        sel_hold_d = sel_hold_q;
        if (w_have) begin
            sel_hold_d = w_winner;
        end
        if (w_out_val && out_rdy) begin
            prio_d  = (w_inc == c_N_EXT) ? '0 : w_inc[p_sbits-1:0];
            state_d = c_ST_OPEN;
        end else if (w_out_val) begin
            state_d    = c_ST_LOCKED;
            lock_idx_d = w_winner;
        end
    end

    // Outputs; forced to zero while reset is asserted, independent of clk.
    always_comb begin
        out_val = 1'b0;
        out_msg = '0;
        grant   = '0;
        in_rdy  = '0;
        sel     = '0;
        if (!reset) begin
            out_val = w_out_val;
            out_msg = w_msg;
            grant   = w_onehot;
            in_rdy  = w_onehot & {p_nreqs{out_rdy}};
            sel     = w_have ? w_winner : sel_hold_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_rr_stream_arbiter
// Purpose  : Directed self-checking bench for vc_rr_stream_arbiter with a
//            4-requester and a 3-requester instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_rr_stream_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   in_val;
    logic [3:0]   in_rdy;
    logic [127:0] in_msg;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  out_msg;
    logic [3:0]   grant;
    logic [1:0]   sel;

    logic [2:0]   in_val3;
    logic [2:0]   in_rdy3;
    logic [95:0]  in_msg3;
    logic         out_val3;
    logic         out_rdy3;
    logic [31:0]  out_msg3;
    logic [2:0]   grant3;
    logic [1:0]   sel3;

    int checks   = 0;
    int failures = 0;

    vc_rr_stream_arbiter #(.p_nbits(32), .p_nreqs(4)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .grant(grant), .sel(sel)
    );

    vc_rr_stream_arbiter #(.p_nbits(32), .p_nreqs(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
        .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3),
        .grant(grant3), .sel(sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        int hs;
        reset    = 1'b1;
        in_val   = 4'b1111;
        out_rdy  = 1'b1;
        in_val3  = 3'b000;
        out_rdy3 = 1'b0;
        for (int i = 0; i < 4; i++) in_msg[i*32 +: 32] = 32'h100 + 32'(i);
        for (int i = 0; i < 3; i++) in_msg3[i*32 +: 32] = 32'h200 + 32'(i);

        // Reset state: everything zero even with requests pending
        #2;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_in_rdy",  64'(in_rdy),  64'd0);
        chk("rst_grant",   64'(grant),   64'd0);
        chk("rst_sel",     64'(sel),     64'd0);
        chk("rst_out_msg", 64'(out_msg), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // All valid, out_rdy=1: one transfer per cycle in 0,1,2,3 order
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant",   64'(grant),   64'(4'b0001 << (c % 4)));
            chk("rr_out_msg", 64'(out_msg), 64'h100 + 64'(c % 4));
            chk("rr_in_rdy",  64'(in_rdy),  64'(4'b0001 << (c % 4)));
            @(negedge clk);
        end

        // Single requester 2, zero-cycle grant; prio -> 3
        in_val = 4'b0100;
        #1;
        chk("single_grant",  64'(grant),  64'b0100);
        chk("single_sel",    64'(sel),    64'd2);
        chk("single_in_rdy", 64'(in_rdy), 64'b0100);
        @(negedge clk);

        // prio=3, requesters 3 and 0: 3 then 0 (wrap-around); prio -> 1
        in_val = 4'b1001;
        #1;
        chk("wrap_grant_a", 64'(grant),   64'b1000);
        chk("wrap_msg_a",   64'(out_msg), 64'h103);
        @(negedge clk);
        #1;
        chk("wrap_grant_b", 64'(grant),   64'b0001);
        @(negedge clk);

        // Requester 3 alone -> prio 0; then idle, sel holds 3
        in_val = 4'b1000;
        #1;
        chk("r3_grant", 64'(grant), 64'b1000);
        @(negedge clk);
        in_val = 4'b0000;
        #1;
        chk("idle_grant",   64'(grant),   64'd0);
        chk("idle_out_val", 64'(out_val), 64'd0);
        chk("idle_sel",     64'(sel),     64'd3);

        // Back-pressure lock on requester 1 (prio=0)
        in_msg[32 +: 32] = 32'hAA;
        in_val  = 4'b0010;
        out_rdy = 1'b0;
        #1;
        chk("lock0_grant",   64'(grant),   64'b0010);
        chk("lock0_msg",     64'(out_msg), 64'hAA);
        chk("lock0_in_rdy",  64'(in_rdy),  64'd0);
        chk("lock0_out_val", 64'(out_val), 64'd1);
        @(negedge clk);
        in_val = 4'b0000;
        #1;
        chk("lock1_grant",   64'(grant),   64'b0010);
        chk("lock1_out_val", 64'(out_val), 64'd0);
        @(negedge clk);
        in_val = 4'b0011;
        #1;
        chk("lock2_grant", 64'(grant),   64'b0010);
        chk("lock2_msg",   64'(out_msg), 64'hAA);
        chk("lock2_sel",   64'(sel),     64'd1);
        @(negedge clk);
        out_rdy = 1'b1;
        #1;
        chk("unlock_in_rdy", 64'(in_rdy),  64'b0010);
        chk("unlock_msg",    64'(out_msg), 64'hAA);
        @(negedge clk);

        // Resume from prio=2: requesters 2,3,0
        in_val = 4'b1101;
        #1;
        chk("resume_2", 64'(grant), 64'b0100);
        @(negedge clk);
        #1;
        chk("resume_3", 64'(grant), 64'b1000);
        @(negedge clk);
        #1;
        chk("resume_0", 64'(grant), 64'b0001);
        @(negedge clk);

        // Lock requester 3 (prio=1), then asynchronous reset mid-lock
        in_val  = 4'b1000;
        out_rdy = 1'b0;
        #1;
        chk("prelock_grant", 64'(grant), 64'b1000);
        @(negedge clk);
        in_val  = 4'b1100;
        out_rdy = 1'b1;
        #1;
        chk("held_grant", 64'(grant), 64'b1000);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_out_val", 64'(out_val), 64'd0);
        chk("arst_in_rdy",  64'(in_rdy),  64'd0);
        chk("arst_grant",   64'(grant),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_grant", 64'(grant), 64'b0100);
        chk("post_rst_sel",   64'(sel),   64'd2);
        @(negedge clk);
        in_val = 4'b0000;

        // 3-requester instance, all valid, out_rdy toggling
        in_val3 = 3'b111;
        k  = 0;
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            out_rdy3 = (c % 2 == 0);
            #1;
            chk("n3_sel", 64'(sel3),     64'(k));
            chk("n3_msg", 64'(out_msg3), 64'h200 + 64'(k));
            if (out_val3 && out_rdy3) hs++;
            if (out_rdy3) k = (k + 1) % 3;
            @(negedge clk);
        end
        chk("n3_transfers", 64'(hs), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
